seg_time_src: RTL and testbench

//  Upstream source for the 6-digit dynamic seven-segment scanner. Generates the
//  1-cycle scan-advance pulse (flag) and a 24-bit BCD time value HH:MM:SS.
//  The time value is controlled by debounced start/pause/clear pulses.

---
 rtl/seg_pkg.sv | 18 +
 rtl/bcd_digit_cnt.sv | 27 ++
 rtl/seg_time_src.sv | 107 ++++++++++
 tb/tb_seg_time_src.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and digit limits for the seven-segment time source
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX           = 4'd9;
    localparam bcd_t SEC_MAX1            = 4'd5;
    localparam bcd_t MIN_MAX1            = 4'd5;
    localparam bcd_t HOUR_TENS_MAX       = 4'd2;
    localparam bcd_t HOUR_UNITS_AT_TENS2 = 4'd3;

endpackage

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - single BCD digit counter with wrap at MAX and synchronous clear
module bcd_digit_cnt
    import seg_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc,
    input  logic sclr,
    output bcd_t q,
    output logic carry
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (sclr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == MAX) ? '0 : q + 4'd1;
        end
    end

    assign carry = inc & (q == MAX);

endmodule

// File: rtl/seg_time_src.sv
// rtl/seg_time_src.sv - scan-advance pulse and run/pause/clear BCD HH:MM:SS clock
module seg_time_src
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50_000,
    parameter int SEC_DIV  = 50_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        key_start,
    input  logic        key_pause,
    input  logic        key_clear,
    output logic        flag,
    output logic [23:0] digits,
    output logic        running
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int SEC_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_wrap;
    logic [SEC_W-1:0]  sec_cnt;
    logic              sec_wrap;
    logic              tick;
    state_t            state;
    state_t            state_nx;

    // Scan divider is independent of the FSM; only reset touches it.
    assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_cnt <= '0;
            flag     <= 1'b0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
            flag     <= scan_wrap;
        end
    end

    assign sec_wrap = (sec_cnt == SEC_W'(SEC_DIV - 1));
    assign tick     = (state == RUN) & sec_wrap;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sec_cnt <= '0;
        end else if (key_clear) begin
            sec_cnt <= '0;
        end else if (state == RUN) begin
            sec_cnt <= sec_wrap ? '0 : sec_cnt + SEC_W'(1);
        end
    end

    // A pause pulse masks start even when the pause itself is ignored.
    always_comb begin
        state_nx = state;
        if (key_clear) begin
            state_nx = IDLE;
        end else if (key_pause) begin
            if (state == RUN) state_nx = PAUSE;
        end else if (key_start && state != RUN) begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == RUN);
        end
    end

    bcd_t s0, s1, m0, m1, h0, h1;
    logic c_s0, c_s1, c_m0, c_m1, c_h0, c_h1;
    logic inc_s0;
    logic hour_sclr;

    assign inc_s0    = tick & ~key_clear;
    assign hour_sclr = key_clear | c_h1
                     | (c_m1 & (h1 == HOUR_TENS_MAX) & (h0 == HOUR_UNITS_AT_TENS2));

    bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_s0 (
        .clk(clk), .rstn(rstn), .inc(inc_s0), .sclr(key_clear), .q(s0), .carry(c_s0)
    );
    bcd_digit_cnt #(.MAX(SEC_MAX1)) u_s1 (
        .clk(clk), .rstn(rstn), .inc(c_s0), .sclr(key_clear), .q(s1), .carry(c_s1)
    );
    bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_m0 (
        .clk(clk), .rstn(rstn), .inc(c_s1), .sclr(key_clear), .q(m0), .carry(c_m0)
    );
    bcd_digit_cnt #(.MAX(MIN_MAX1)) u_m1 (
        .clk(clk), .rstn(rstn), .inc(c_m0), .sclr(key_clear), .q(m1), .carry(c_m1)
    );
    bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_h0 (
        .clk(clk), .rstn(rstn), .inc(c_m1), .sclr(hour_sclr), .q(h0), .carry(c_h0)
    );
    bcd_digit_cnt #(.MAX(HOUR_TENS_MAX)) u_h1 (
        .clk(clk), .rstn(rstn), .inc(c_h0), .sclr(hour_sclr), .q(h1), .carry(c_h1)
    );

    assign digits = {h1, h0, m1, m0, s1, s0};

endmodule

// File: tb/tb_seg_time_src.sv
// tb/tb_seg_time_src.sv - directed-vector bench for seg_time_src
module tb_seg_time_src;

    logic        clk = 1'b0;
    logic        rstn, key_start, key_pause, key_clear;
    logic        flag, running;
    logic [23:0] digits;

    logic        rstn_b, key_start_b, key_pause_b, key_clear_b;
    logic        flag_b, running_b;
    logic [23:0] digits_b;

    int n_vec = 0;
    int n_bad = 0;
    int cyc;
    bit done_b = 1'b0;

    always #5 clk = ~clk;

    seg_time_src #(.SCAN_DIV(4), .SEC_DIV(10)) dut (
        .clk(clk), .rstn(rstn), .key_start(key_start), .key_pause(key_pause),
        .key_clear(key_clear), .flag(flag), .digits(digits), .running(running)
    );

    seg_time_src #(.SCAN_DIV(4), .SEC_DIV(1)) dut_b (
        .clk(clk), .rstn(rstn_b), .key_start(key_start_b), .key_pause(key_pause_b),
        .key_clear(key_clear_b), .flag(flag_b), .digits(digits_b), .running(running_b)
    );

    // Edges since the last reset release; flag is expected on multiples of 4.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit s, input bit p, input bit c);
        key_start = s;
        key_pause = p;
        key_clear = c;
        step(1);
        key_start = 1'b0;
        key_pause = 1'b0;
        key_clear = 1'b0;
    endtask

    task automatic check_cadence(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            check_vec(tag, {31'd0, flag}, {31'd0, (cyc % 4) == 0});
        end
    endtask

    // Full-day rollover on the SEC_DIV=1 instance, running alongside the main sequence.
    initial begin
        rstn_b = 1'b0; key_start_b = 1'b0; key_pause_b = 1'b0; key_clear_b = 1'b0;
        #22;
        @(negedge clk) rstn_b = 1'b1;
        step(1);
        key_start_b = 1'b1;
        step(1);
        key_start_b = 1'b0;
        check_vec("b_running", {31'd0, running_b}, 32'd1);
        step(3600);
        check_vec("b_one_hour", {8'd0, digits_b}, 32'h010000);
        step(86399 - 3600);
        check_vec("b_235959", {8'd0, digits_b}, 32'h235959);
        step(1);
        check_vec("b_rollover", {8'd0, digits_b}, 32'h000000);
        check_vec("b_still_run", {31'd0, running_b}, 32'd1);
        done_b = 1'b1;
    end

    initial begin
        rstn = 1'b0; key_start = 1'b0; key_pause = 1'b0; key_clear = 1'b0;
        #22;
        check_vec("rst_flag", {31'd0, flag}, 32'd0);
        check_vec("rst_digits", {8'd0, digits}, 32'd0);
        check_vec("rst_running", {31'd0, running}, 32'd0);
        @(negedge clk) rstn = 1'b1;

        check_cadence("idle_flag", 12);
        check_vec("idle_digits", {8'd0, digits}, 32'd0);
        check_vec("idle_running", {31'd0, running}, 32'd0);

        press(1, 0, 0);
        check_vec("start_running", {31'd0, running}, 32'd1);
        step(9);
        check_vec("pre_first_sec", {8'd0, digits}, 32'd0);
        step(1);
        check_vec("first_sec", {8'd0, digits}, 32'h000001);
        step(590);
        check_vec("one_minute", {8'd0, digits}, 32'h000100);

        press(0, 0, 1);
        check_vec("clear_digits", {8'd0, digits}, 32'd0);
        check_vec("clear_running", {31'd0, running}, 32'd0);
        press(1, 0, 0);
        step(4);
        press(0, 1, 0);
        check_vec("pause_running", {31'd0, running}, 32'd0);
        step(100);
        check_vec("pause_hold", {8'd0, digits}, 32'd0);
        press(1, 0, 0);
        step(4);
        check_vec("resume_pre", {8'd0, digits}, 32'd0);
        step(1);
        check_vec("resume_partial", {8'd0, digits}, 32'h000001);

        step(9);
        press(1, 0, 1);
        check_vec("clr_tick_digits", {8'd0, digits}, 32'd0);
        check_vec("clr_tick_running", {31'd0, running}, 32'd0);
        check_cadence("clr_flag", 8);

        press(1, 1, 0);
        check_vec("start_pause_idle", {31'd0, running}, 32'd0);
        step(20);
        check_vec("idle_no_count", {8'd0, digits}, 32'd0);

        press(1, 0, 0);
        step(9);
        press(0, 1, 0);
        check_vec("pause_tick_digits", {8'd0, digits}, 32'h000001);
        check_vec("pause_tick_running", {31'd0, running}, 32'd0);
        step(20);
        check_vec("pause_tick_hold", {8'd0, digits}, 32'h000001);
        press(1, 0, 0);
        step(9);
        check_vec("after_pt_pre", {8'd0, digits}, 32'h000001);
        step(1);
        check_vec("after_pt_sec", {8'd0, digits}, 32'h000002);

        press(0, 0, 1);
        press(1, 0, 0);
        step(420);
        check_vec("digits_42", {8'd0, digits}, 32'h000042);
        #3;
        rstn = 1'b0;
        #1;
        check_vec("arst_flag", {31'd0, flag}, 32'd0);
        check_vec("arst_digits", {8'd0, digits}, 32'd0);
        check_vec("arst_running", {31'd0, running}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        check_cadence("post_rst_flag", 8);
        check_vec("post_rst_running", {31'd0, running}, 32'd0);

        for (int i = 0; i < 100000 && !done_b; i++) step(1);
        check_vec("b_done", {31'd0, done_b}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
